fp_result_queue: RTL and testbench
==================================

Name: fp_result_queue

Overview:
- Downstream consumer of float_alu.
- Accepts completed results (result + 5-bit exception flags) through the ALU's valid_out/ready_in handshake and buffers them in a small FIFO.
- Presents buffered results in order to the writeback/host side through a valid/ready interface.
- Maintains a sticky accumulated-exception register (fflags) that software reads and clears.

Parameters:
- N, 32, result width in bits; equals float_alu N.
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.
- AW, $clog2(DEPTH), pointer width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- alu_valid  input  1  float_alu valid_out.
- alu_result  input  N  float_alu result.
- alu_flags  input  5  float_alu flags. Bit order: [4]=NV, [3]=DZ, [2]=OF, [1]=UF, [0]=NX.
- alu_ready  output  1  drives float_alu ready_in. High when the queue can accept an entry.
- out_valid  output  1  head entry available.
- out_ready  input  1  downstream accepts the head entry.
- out_result  output  N  head entry result.
- out_flags  output  5  head entry flags.
- clear_flags  input  1  one-cycle pulse that clears fflags.
- fflags  output  5  sticky OR of the flags of all pushed entries since the last clear or reset.
- count  output  AW+1  number of valid entries, 0..DEPTH.

Behaviour:
- Clocking and reset: single clock domain. All state updates on the rising clk edge.
- When rst=1 at an edge:
  - wr_ptr, rd_ptr, count and fflags are set to 0.
  - Storage contents are left unchanged (don't-care).
- After reset: out_valid=0, alu_ready=1, out_result=0, out_flags=0, fflags=0, count=0.
- rst overrides every other input in the same cycle.
- Push: push = alu_valid && alu_ready.
  - Writes {alu_result, alu_flags} to mem[wr_ptr].
  - wr_ptr increments modulo DEPTH, with natural wrap at AW bits.
- Pop: pop = out_valid && out_ready. rd_ptr increments modulo DEPTH.
- count update:
  - count_next = count + push - pop.
  - A simultaneous push and pop leaves count unchanged.
- Status outputs:
  - alu_ready = (count != DEPTH). It is a combinational function of registered state only; there is no combinational path from out_ready.
  - out_valid = (count != 0).
- Full: alu_ready=0, so the ALU holds its result. A pop in the same cycle does not enable a push; the push is accepted on the following cycle.
- Empty: out_valid=0 and out_result/out_flags are driven to 0. The output side ignores out_ready.
- Latency:
  - An entry pushed at edge k is visible on out_* from edge k onward, i.e. in the cycle after the handshake.
  - There is no same-cycle bypass from alu_* to out_*.
- Output data:
  - out_result/out_flags = mem[rd_ptr] whenever out_valid=1.
  - They remain stable while out_valid=1 and out_ready=0.
- Ordering: strict FIFO order. No entry is dropped or duplicated.
- Sticky flags, evaluated at each edge with rst=0:
  - If clear_flags=1 and push=1: fflags_next = alu_flags. Clear is applied first, then the push is ORed in.
  - If clear_flags=1 and push=0: fflags_next = 0.
  - Otherwise, if push=1: fflags_next = fflags | alu_flags.
  - Otherwise: fflags is held.
  - fflags is updated on push, not on pop.
- Protocol assumptions on the ALU side:
  - alu_result/alu_flags are stable while alu_valid=1 and alu_ready=0.
  - The queue does not check this.
- Mid-operation reset:
  - Resetting while entries are held discards them; out_valid falls in the cycle after the reset edge.
  - alu_ready rises after reset even if alu_valid is held high. The next non-reset edge may then push.

Test Plan:
- Reset then single push:
  - Stimulus: alu_valid=1, alu_result=32'h3FC00000, alu_flags=5'b00001 for one cycle; out_ready=0.
  - Required: next cycle out_valid=1, out_result=32'h3FC00000, out_flags=5'b00001, count=1, fflags=5'b00001.
- Fill to full (DEPTH=4):
  - Stimulus: push 32'h1, 32'h2, 32'h3, 32'h4 with out_ready=0.
  - Required: count=4, alu_ready=0.
  - Stimulus: keep alu_valid=1 with 32'h5.
  - Required: no push while full. Raise out_ready for one cycle: pop returns 32'h1, count=3, alu_ready=1. 32'h5 is pushed on the next edge.
- Wrap-around ordering:
  - Stimulus: stream 10 values 32'hA0..32'hA9 with alu_valid=1 and out_ready=1 every cycle.
  - Required: out_result sequence is A0..A9 in order with no gaps or duplicates; count never exceeds 1.
- Simultaneous push and pop:
  - Stimulus: with count=2, push 32'hBEEF and pop in the same cycle.
  - Required: count stays 2, head advances, 32'hBEEF is enqueued at the tail.
- Sticky flags:
  - Stimulus: push flags 5'b00100, then 5'b10000.
  - Required: fflags=5'b10100.
  - Stimulus: clear_flags=1 together with a push of flags 5'b00010.
  - Required: fflags=5'b00010.
  - Stimulus: clear_flags=1 with no push.
  - Required: fflags=0.
- Reset mid-operation:
  - Stimulus: with count=3 and fflags=5'b11111, assert rst for one cycle while alu_valid=1.
  - Required: next cycle count=0, out_valid=0, fflags=0, alu_ready=1, out_result=0.

Source files
------------

// File: rtl/fp_result_queue_if.sv
// fp_result_queue_if: ALU-side push, writeback-side pop and sticky-flag signals of the result queue
interface fp_result_queue_if #(parameter int N = 32, parameter int DEPTH = 4);
    localparam int AW = $clog2(DEPTH);
    logic         alu_valid;
    logic [N-1:0] alu_result;
    logic [4:0]   alu_flags;
    logic         alu_ready;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_result;
    logic [4:0]   out_flags;
    logic         clear_flags;
    logic [4:0]   fflags;
    logic [AW:0]  count;
    modport slave (
        input  alu_valid, alu_result, alu_flags, out_ready, clear_flags,
        output alu_ready, out_valid, out_result, out_flags, fflags, count
    );
    modport master (
        output alu_valid, alu_result, alu_flags, out_ready, clear_flags,
        input  alu_ready, out_valid, out_result, out_flags, fflags, count
    );
endinterface

// File: rtl/fp_result_queue.sv
// fp_result_queue: buffers float_alu results in a FIFO and accumulates sticky exception flags
module fp_result_queue #(
    parameter int N     = 32,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input logic              clk,
    input logic              rst,
    fp_result_queue_if.slave q
);
    logic [N+4:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic [4:0]    flags_r;
    logic          push, pop;

    assign q.alu_ready  = cnt != (AW+1)'(DEPTH);
    assign q.out_valid  = cnt != '0;
    assign push         = q.alu_valid && q.alu_ready;
    assign pop          = q.out_valid && q.out_ready;
    assign q.out_result = q.out_valid ? mem[rd_ptr][N+4:5] : '0;
    assign q.out_flags  = q.out_valid ? mem[rd_ptr][4:0] : '0;
    assign q.count      = cnt;
    assign q.fflags     = flags_r;

    // storage is not reset; only entries below count are ever observed
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {q.alu_result, q.alu_flags};

    // pointers, occupancy and sticky flags; a clear drops old flags but keeps a same-cycle push
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            flags_r <= '0;
        end else begin
            wr_ptr  <= wr_ptr + AW'(push);
            rd_ptr  <= rd_ptr + AW'(pop);
            cnt     <= cnt + (AW+1)'(push) - (AW+1)'(pop);
            flags_r <= (flags_r & {5{~q.clear_flags}}) | (q.alu_flags & {5{push}});
        end
    end
endmodule

// File: tb/tb_fp_result_queue.sv
// tb_fp_result_queue: directed stimulus with a scoreboard-based output monitor
module tb_fp_result_queue;
    logic clk = 0;
    logic rst = 1;
    int   checks = 0;
    int   errors = 0;
    logic [36:0] exp_q [$];

    always #5 clk = ~clk;

    fp_result_queue_if #(.N(32), .DEPTH(4)) q ();
    fp_result_queue #(.N(32), .DEPTH(4)) dut (.clk(clk), .rst(rst), .q(q));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // record every accepted push as the expected future output
    always @(negedge clk)
        if (!rst && q.alu_valid && q.alu_ready) exp_q.push_back({q.alu_result, q.alu_flags});

    // compare every accepted pop against the oldest expected entry
    always @(negedge clk)
        if (!rst && q.out_valid && q.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_underflow: got %0h expected none", {q.out_result, q.out_flags});
            end else
                check("pop_data", {q.out_result, q.out_flags}, exp_q.pop_front());
        end

    initial begin
        q.alu_valid = 0; q.alu_result = '0; q.alu_flags = '0;
        q.out_ready = 0; q.clear_flags = 0;
        tick; tick;
        rst = 0;
        check("rst_out_valid", q.out_valid, 0);
        check("rst_alu_ready", q.alu_ready, 1);
        check("rst_out_result", q.out_result, 0);
        check("rst_out_flags", q.out_flags, 0);
        check("rst_fflags", q.fflags, 0);
        check("rst_count", q.count, 0);

        q.alu_valid = 1; q.alu_result = 32'h3FC00000; q.alu_flags = 5'b00001;
        tick;
        q.alu_valid = 0;
        check("single_out_valid", q.out_valid, 1);
        check("single_out_result", q.out_result, 32'h3FC00000);
        check("single_out_flags", q.out_flags, 5'b00001);
        check("single_count", q.count, 1);
        check("single_fflags", q.fflags, 5'b00001);
        q.out_ready = 1; tick; q.out_ready = 0;
        check("drain1_count", q.count, 0);
        check("pop_keeps_fflags", q.fflags, 5'b00001);
        check("empty_out_result", q.out_result, 0);

        for (int i = 1; i <= 4; i++) begin
            q.alu_valid = 1; q.alu_result = 32'(i); q.alu_flags = 5'b0;
            tick;
        end
        check("full_count", q.count, 4);
        check("full_alu_ready", q.alu_ready, 0);
        q.alu_result = 32'h5;
        tick;
        check("full_hold_count", q.count, 4);
        check("full_stable_head", q.out_result, 32'h1);
        q.out_ready = 1; tick; q.out_ready = 0;
        check("full_pop_count", q.count, 3);
        check("full_pop_alu_ready", q.alu_ready, 1);
        tick;
        q.alu_valid = 0;
        check("late_push_count", q.count, 4);
        q.out_ready = 1;
        repeat (4) tick;
        q.out_ready = 0;
        check("drain2_count", q.count, 0);

        q.out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            q.alu_valid = 1; q.alu_result = 32'hA0 + 32'(i); q.alu_flags = 5'b0;
            tick;
            check("stream_count_le1", 64'(q.count <= 1), 1);
        end
        q.alu_valid = 0;
        tick;
        q.out_ready = 0;
        check("stream_count", q.count, 0);
        check("stream_all_seen", exp_q.size(), 0);

        q.alu_valid = 1; q.alu_result = 32'h11; tick;
        q.alu_result = 32'h22; tick;
        check("pp_pre_count", q.count, 2);
        q.alu_result = 32'hBEEF; q.out_ready = 1; tick;
        q.alu_valid = 0; q.out_ready = 0;
        check("pp_count", q.count, 2);
        check("pp_head", q.out_result, 32'h22);
        q.out_ready = 1; tick; tick; q.out_ready = 0;
        check("pp_drain_count", q.count, 0);

        q.clear_flags = 1; tick; q.clear_flags = 0;
        check("clear_idle", q.fflags, 0);
        q.alu_valid = 1; q.alu_result = 32'h1; q.alu_flags = 5'b00100; tick;
        q.alu_result = 32'h2; q.alu_flags = 5'b10000; tick;
        q.alu_valid = 0;
        check("sticky_or", q.fflags, 5'b10100);
        q.clear_flags = 1; q.alu_valid = 1; q.alu_result = 32'h3; q.alu_flags = 5'b00010; tick;
        q.clear_flags = 0; q.alu_valid = 0;
        check("clear_with_push", q.fflags, 5'b00010);
        q.clear_flags = 1; tick; q.clear_flags = 0;
        check("clear_no_push", q.fflags, 0);

        q.alu_valid = 1; q.alu_result = 32'h4; q.alu_flags = 5'b11111; q.out_ready = 1; tick;
        q.out_ready = 0;
        check("premid_count", q.count, 3);
        check("premid_fflags", q.fflags, 5'b11111);
        q.alu_result = 32'h99; q.alu_flags = 5'b0; rst = 1; tick; rst = 0;
        exp_q.delete();
        check("mid_rst_count", q.count, 0);
        check("mid_rst_out_valid", q.out_valid, 0);
        check("mid_rst_fflags", q.fflags, 0);
        check("mid_rst_alu_ready", q.alu_ready, 1);
        check("mid_rst_out_result", q.out_result, 0);
        tick;
        q.alu_valid = 0;
        check("post_rst_push_count", q.count, 1);
        q.out_ready = 1; tick; q.out_ready = 0;
        check("final_count", q.count, 0);
        check("final_scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
